// File: rtl/pipe_ctrl.sv
// N-stage valid/instruction pipeline sequencer for the 9-bit CPU.
// Adds load-use stall, taken-branch flush of younger stages and halt drain.
module pipe_ctrl #(
    parameter int unsigned IW        = 9,
    parameter int unsigned STAGES    = 5,
    parameter int unsigned BR_STAGE  = 2,
    parameter int unsigned CNT_W     = 16,
    parameter logic [IW-1:0] HALT_WORD = 9'b110111000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_valid,
    input  logic [IW-1:0]        fetch_instr,
    output logic                 fetch_ready,
    input  logic                 takeit,
    output logic [STAGES-1:0]    stage_valid,
    output logic [STAGES*IW-1:0] stage_instr,
    output logic                 stall,
    output logic                 flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     retire_count
);

    localparam int unsigned LAST      = STAGES - 1;
    localparam int unsigned OP_W      = 3;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'b010;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'b101;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [IW-1:0]     instr_q [STAGES];
    logic [IW-1:0]     instr_d [STAGES];
    logic              halt_pend_q;
    logic              halt_pend_d;
    logic              halted_q;
    logic              halted_d;
    logic              drained_q;
    logic [CNT_W-1:0]  count_q;

    logic load_use;
    logic br_taken;
    logic accept;
    logic retire;
    logic halt_flushed;

    // Hazard detection from the stage registers
    always_comb begin
        load_use = valid_q[2] && valid_q[1]
                   && (instr_q[2][IW-1 -: OP_W] == OP_LOAD)
                   && !instr_q[2][5]
                   && ((instr_q[2][5:3] == instr_q[1][5:3])
                       || (instr_q[2][5:3] == instr_q[1][2:0]));
        br_taken = valid_q[BR_STAGE] && takeit
                   && (instr_q[BR_STAGE][IW-1 -: OP_W] == OP_BRANCH);
    end

    assign flush       = br_taken & ~halted_q;
    assign stall       = load_use & ~halted_q & ~flush;
    assign fetch_ready = ~stall & ~halt_pend_q & ~halted_q;
    assign accept      = fetch_valid & fetch_ready;

    // A halt sitting in a stage that the branch flushes cancels the drain
    always_comb begin
        halt_flushed = 1'b0;
        for (int unsigned k = 1; k < BR_STAGE; k++) begin
            if (valid_q[k] && (instr_q[k] == HALT_WORD)) begin
                halt_flushed = 1'b1;
            end
        end
    end

    // Next-state: halted freezes, then flush > stall > advance
    always_comb begin
        valid_d     = valid_q;
        instr_d     = instr_q;
        halt_pend_d = halt_pend_q;
        halted_d    = halted_q;

        if (halted_q) begin
            valid_d = valid_q;
        end else if (flush) begin
            valid_d[0] = 1'b0;
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (k > BR_STAGE) begin
                    valid_d[k] = valid_q[k-1];
                    instr_d[k] = instr_q[k-1];
                end else begin
                    valid_d[k] = 1'b0;
                end
            end
        end else if (stall) begin
            valid_d[2] = 1'b0;
            for (int unsigned k = 3; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                instr_d[k] = instr_q[k-1];
            end
        end else begin
            valid_d[0] = accept;
            if (accept) begin
                instr_d[0] = fetch_instr;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                instr_d[k] = instr_q[k-1];
            end
        end

        if (!halted_q) begin
            if (flush && halt_flushed) begin
                halt_pend_d = 1'b0;
            end else if (!flush && valid_q[1] && (instr_q[1] == HALT_WORD)) begin
                halt_pend_d = 1'b1;
            end
        end

        halted_d = halted_q | (valid_d[LAST] & (instr_d[LAST] == HALT_WORD));
    end

    // The halt itself retires on the edge after it lands in WB, then the count freezes
    assign retire = valid_q[LAST] & ~drained_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                instr_q[k] <= '0;
            end
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            drained_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
            drained_q   <= halted_q;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign stage_instr[g*IW +: IW] = instr_q[g];
    end

    assign stage_valid  = valid_q;
    assign halted       = halted_q;
    assign retire_count = count_q;

endmodule
